cp0_unit: RTL and testbench
===========================

Name: cp0_unit

Overview:
- Coprocessor-0 for the multicycle MIPS core; sits directly downstream of the core's cp0 interface: it consumes cp0we/cp0addr/write data/exlset/exlclr/pc4 and produces cp0rd, epcin and intreq.
- Holds SR, Cause, EPC and PRId.
- Latches the six external hardware interrupt lines and produces the single interrupt request the control unit samples.

Parameters:
- PRID_VAL, 32'h0000_1902, value returned on reads of PRId (reg 15).

Ports:
- clk  in  1  system clock, all state on rising edge
- reset  in  1  synchronous, active-low; state clears on a rising clk edge while reset==0
- we  in  1  cp0 write enable (core cp0we, mtc0)
- addr  in  5  cp0 register index (core rd field)
- wdata  in  32  write data (core GPR rt value)
- rdata  out  32  combinational read of register at addr (mfc0)
- pc_in  in  32  core PC at interrupt entry (pc4)
- exlset  in  1  interrupt entry: set EXL, capture EPC
- exlclr  in  1  eret: clear EXL
- hwint  in  6  external device interrupt lines, level-sensitive
- epc_out  out  32  current EPC to core npc (epcin)
- intreq  out  1  interrupt request to control unit

Behaviour:
- Reset (reset==0 at edge): SR=0 (IM=0, EXL=0, IE=0), Cause.IP=0, EPC=0. Resulting outputs: intreq=0, epc_out=0, rdata follows addr.
- SR (reg 12): IM=[15:10], EXL=[1], IE=[0]. Other bits read 0, writes to them are discarded.
- Cause (reg 13): IP=[15:10], ExcCode=[6:2], always 0 (interrupt only). Software-read-only; writes ignored.
- EPC (reg 14): 32-bit, bits[1:0] forced 0 on every load.
- PRId (reg 15): constant PRID_VAL; writes ignored.
- Any other addr: rdata=0, writes ignored.
- IP update: Cause.IP <= hwint every cycle (1-cycle registered sample, no sticky latch). Clearing a device line clears IP on the next edge.
- intreq = |(Cause.IP & SR.IM) & SR.IE & ~SR.EXL. Combinational from registered state only, so hwint reaches intreq with exactly 1 cycle of latency.
- exlset at edge: EXL<=1, EPC<={pc_in[31:2],2'b00}.
- exlclr at edge: EXL<=0.
- exlset and exlclr in the same cycle: exlset wins (EXL=1, EPC captured).
- we to SR with exlset in the same cycle: IM/IE take wdata; EXL takes 1.
- we to SR with exlclr (no exlset) in the same cycle: EXL takes 0.
- we to EPC with exlset in the same cycle: exlset capture wins.
- Write timing: mtc0 is visible on rdata and intreq the cycle after the edge.
- Read bypass: none. A read in the same cycle as a write returns the old value.
- Reset asserted mid-interrupt-entry: reset dominates all other inputs.

Optional Feature:
- Macro CP0_TIMER_EN.
- Defined: adds Count (reg 9) and Compare (reg 11).
  - Count increments by 1 every cycle and wraps 32'hFFFF_FFFF->0.
  - mtc0 Count loads wdata instead of incrementing that cycle.
  - Timer-pending flag sets when Count==Compare and Compare!=0.
  - mtc0 Compare loads Compare and clears the flag; a clear wins over a set in the same cycle.
  - Cause.IP[15] = hwint[5] | flag.
  - Reset: Count=0, Compare=0, flag=0.
- Undefined: regs 9/11 read 0, writes ignored, IP[15]=hwint[5].

Decomposition:
- Shared package cp0_pkg:
  - register index constants (CP0_SR=12, CP0_CAUSE=13, CP0_EPC=14, CP0_PRID=15, CP0_COUNT=9, CP0_COMPARE=11)
  - SR/Cause bit-position constants
  - ExcCode value for interrupt (0)
- One natural sub-module: cp0_timer (Count/Compare/flag), instantiated only under CP0_TIMER_EN.

Test Plan:
- Reset: drive reset=0 for 2 cycles with hwint=6'h3F -> SR=0, Cause=0, EPC=0, intreq=0. Release reset -> next cycle Cause=32'h0000_FC00, intreq still 0.
- Enable: mtc0 SR=32'h0000_0401 (IM0, IE), then hwint=6'h01 at cycle N -> Cause.IP=6'h01 after edge N, intreq=1 at cycle N+1. With hwint=6'h02 instead -> intreq stays 0.
- Entry/return: with intreq=1, pulse exlset with pc_in=32'h0000_3047 -> EPC=32'h0000_3044, epc_out matches, SR reads 32'h0000_0403, intreq=0. Pulse exlclr -> EXL=0, intreq=1 again if hwint still high.
- Collision: exlset=1, exlclr=1 and we to EPC with wdata=32'h1234_5678 in the same cycle -> EXL=1, EPC={pc_in[31:2],2'b00}.
- Ignored writes/reads: mtc0 to PRId, Cause and reg 3 -> rdata=PRID_VAL, 32'h0 (with hwint=0) and 32'h0 respectively.
- Timer (CP0_TIMER_EN, IM5 and IE set):
  - mtc0 Compare=10 and Count=0 -> intreq=1 one cycle after Count reaches 10.
  - mtc0 Compare=10 again -> intreq=0.
  - Count preset 32'hFFFF_FFFF -> reads 0 next cycle.

Source files
------------

// File: rtl/cp0_pkg.sv
// Shared constants for the coprocessor-0 unit: register indices, field positions, exception codes.
package cp0_pkg;

   localparam int unsigned XLEN      = 32;
   localparam int unsigned AW        = 5;
   localparam int unsigned NUM_HWINT = 6;
   localparam int unsigned EXC_W     = 5;

   // Register indices
   localparam logic [AW-1:0] CP0_COUNT   = 5'd9;
   localparam logic [AW-1:0] CP0_COMPARE = 5'd11;
   localparam logic [AW-1:0] CP0_SR      = 5'd12;
   localparam logic [AW-1:0] CP0_CAUSE   = 5'd13;
   localparam logic [AW-1:0] CP0_EPC     = 5'd14;
   localparam logic [AW-1:0] CP0_PRID    = 5'd15;

   // SR field positions
   localparam int unsigned SR_IM_LO = 10;
   localparam int unsigned SR_IM_HI = 15;
   localparam int unsigned SR_EXL   = 1;
   localparam int unsigned SR_IE    = 0;

   // Cause field positions
   localparam int unsigned CAUSE_IP_LO  = 10;
   localparam int unsigned CAUSE_IP_HI  = 15;
   localparam int unsigned CAUSE_EXC_LO = 2;
   localparam int unsigned CAUSE_EXC_HI = 6;

   // Only interrupts are taken, so ExcCode is always Int
   localparam logic [EXC_W-1:0] EXC_INT = 5'd0;

   // EPC is always word aligned
   localparam logic [XLEN-1:0] EPC_MASK = 32'hFFFF_FFFC;

endpackage : cp0_pkg

// File: rtl/cp0_timer.sv
// Count/Compare timer for cp0: free-running counter with a sticky compare-match flag.
module cp0_timer
   import cp0_pkg::*;
(
   input  logic            clk,
   input  logic            reset,
   input  logic            i_we_count,
   input  logic            i_we_compare,
   input  logic [XLEN-1:0] i_wdata,
   output logic [XLEN-1:0] o_count,
   output logic [XLEN-1:0] o_compare,
   output logic            o_flag
);

   logic [XLEN-1:0] r_count;
   logic [XLEN-1:0] r_compare;
   logic            r_flag;
   logic            w_match;

   // A zero Compare means the timer interrupt is disarmed
   assign w_match = (r_count == r_compare) && (r_compare != '0);

   // Counter increments every cycle unless software loads it
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_count <= '0;
      end else if (i_we_count) begin
         r_count <= i_wdata;
      end else begin
         r_count <= r_count + XLEN'(1);
      end
   end

   // Compare load also acknowledges the pending flag; the acknowledge beats a new match
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_compare <= '0;
         r_flag    <= 1'b0;
      end else if (i_we_compare) begin
         r_compare <= i_wdata;
         r_flag    <= 1'b0;
      end else if (w_match) begin
         r_flag    <= 1'b1;
      end
   end

   assign o_count   = r_count;
   assign o_compare = r_compare;
   assign o_flag    = r_flag;

endmodule : cp0_timer

// File: rtl/cp0_unit.sv
// Coprocessor-0 for the multicycle MIPS core: SR, Cause, EPC, PRId and interrupt request.
// Optional Count/Compare timer is built when CP0_TIMER_EN is defined.
module cp0_unit
   import cp0_pkg::*;
#(
   parameter logic [31:0] PRID_VAL = 32'h0000_1902
)(
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 we,
   input  logic [AW-1:0]        addr,
   input  logic [XLEN-1:0]      wdata,
   output logic [XLEN-1:0]      rdata,
   input  logic [XLEN-1:0]      pc_in,
   input  logic                 exlset,
   input  logic                 exlclr,
   input  logic [NUM_HWINT-1:0] hwint,
   output logic [XLEN-1:0]      epc_out,
   output logic                 intreq
);

   logic [NUM_HWINT-1:0] r_im;
   logic                 r_exl;
   logic                 r_ie;
   logic [NUM_HWINT-1:0] r_ip;
   logic [XLEN-1:0]      r_epc;

   logic                 w_we_sr;
   logic                 w_we_epc;
   logic                 w_tflag;
   logic [NUM_HWINT-1:0] w_ip_view;
   logic [XLEN-1:0]      w_sr_rd;
   logic [XLEN-1:0]      w_cause_rd;
   logic [XLEN-1:0]      w_epc_entry;

   assign w_we_sr     = we && (addr == CP0_SR);
   assign w_we_epc    = we && (addr == CP0_EPC);
   assign w_epc_entry = pc_in & EPC_MASK;

`ifdef CP0_TIMER_EN
   logic            w_we_count;
   logic            w_we_compare;
   logic [XLEN-1:0] w_count;
   logic [XLEN-1:0] w_compare;

   assign w_we_count   = we && (addr == CP0_COUNT);
   assign w_we_compare = we && (addr == CP0_COMPARE);

   cp0_timer u_timer (
      .clk          (clk),
      .reset        (reset),
      .i_we_count   (w_we_count),
      .i_we_compare (w_we_compare),
      .i_wdata      (wdata),
      .o_count      (w_count),
      .o_compare    (w_compare),
      .o_flag       (w_tflag)
   );
`else
   assign w_tflag = 1'b0;
`endif

   // Timer pending shares the top interrupt line with hwint[5]
   assign w_ip_view = {r_ip[NUM_HWINT-1] | w_tflag, r_ip[NUM_HWINT-2:0]};

   // Interrupt sampling and status/mask register updates
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_ip  <= '0;
         r_im  <= '0;
         r_ie  <= 1'b0;
         r_exl <= 1'b0;
      end else begin
         r_ip <= hwint;
         if (w_we_sr) begin
            r_im <= wdata[SR_IM_HI:SR_IM_LO];
            r_ie <= wdata[SR_IE];
         end
         // Hardware entry/return takes precedence over a software EXL write
         if (exlset) begin
            r_exl <= 1'b1;
         end else if (exlclr) begin
            r_exl <= 1'b0;
         end else if (w_we_sr) begin
            r_exl <= wdata[SR_EXL];
         end
      end
   end

   // EPC capture on interrupt entry, otherwise software load
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_epc <= '0;
      end else if (exlset) begin
         r_epc <= w_epc_entry;
      end else if (w_we_epc) begin
         r_epc <= wdata & EPC_MASK;
      end
   end

   // Readable images of SR and Cause
   always_comb begin
      w_sr_rd                           = '0;
      w_sr_rd[SR_IM_HI:SR_IM_LO]        = r_im;
      w_sr_rd[SR_EXL]                   = r_exl;
      w_sr_rd[SR_IE]                    = r_ie;
      w_cause_rd                        = '0;
      w_cause_rd[CAUSE_IP_HI:CAUSE_IP_LO]   = w_ip_view;
      w_cause_rd[CAUSE_EXC_HI:CAUSE_EXC_LO] = EXC_INT;
   end

   // mfc0 read mux, no write bypass
   always_comb begin
      rdata = '0;
      case (addr)
         CP0_SR:      rdata = w_sr_rd;
         CP0_CAUSE:   rdata = w_cause_rd;
         CP0_EPC:     rdata = r_epc;
         CP0_PRID:    rdata = PRID_VAL;
`ifdef CP0_TIMER_EN
         CP0_COUNT:   rdata = w_count;
         CP0_COMPARE: rdata = w_compare;
`endif
         default:     rdata = '0;
      endcase
   end

   assign epc_out = r_epc;
   assign intreq  = (|(w_ip_view & r_im)) & r_ie & ~r_exl;

endmodule : cp0_unit

// File: tb/tb_cp0_unit.sv
// Directed self-checking bench for cp0_unit (timer checks enabled with CP0_TIMER_EN).
module tb_cp0_unit;

   logic        clk;
   logic        reset;
   logic        we;
   logic [4:0]  addr;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic [31:0] pc_in;
   logic        exlset;
   logic        exlclr;
   logic [5:0]  hwint;
   logic [31:0] epc_out;
   logic        intreq;

   int n_checks = 0;
   int n_fail   = 0;

   cp0_unit #(.PRID_VAL(32'h0000_1902)) dut (
      .clk     (clk),
      .reset   (reset),
      .we      (we),
      .addr    (addr),
      .wdata   (wdata),
      .rdata   (rdata),
      .pc_in   (pc_in),
      .exlset  (exlset),
      .exlclr  (exlclr),
      .hwint   (hwint),
      .epc_out (epc_out),
      .intreq  (intreq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Advance past one rising edge; inputs change and outputs are sampled 1ns later
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic rd(input string tag, input logic [4:0] a, input logic [31:0] exp);
      addr = a;
      #1;
      check(tag, rdata, exp);
   endtask

   task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
      we = 1'b1; addr = a; wdata = d;
      step();
      we = 1'b0;
   endtask

   initial begin
      reset = 1'b0; we = 1'b0; addr = '0; wdata = '0; pc_in = '0;
      exlset = 1'b0; exlclr = 1'b0; hwint = 6'h3F;

      // Reset with all lines high
      step(); step();
      rd("rst_sr", 5'd12, 32'h0);
      rd("rst_cause", 5'd13, 32'h0);
      rd("rst_epc", 5'd14, 32'h0);
      check("rst_epc_out", 32'(epc_out), 32'h0);
      check("rst_intreq", 32'(intreq), 32'h0);

      reset = 1'b1;
      step();
      rd("post_rst_cause", 5'd13, 32'h0000_FC00);
      check("post_rst_intreq", 32'(intreq), 32'h0);

      // Enable IM0 + IE
      hwint = 6'h00;
      step();
      mtc0(5'd12, 32'h0000_0401);
      rd("sr_en", 5'd12, 32'h0000_0401);
      check("en_no_ip", 32'(intreq), 32'h0);

      hwint = 6'h01;
      check("hw_not_yet", 32'(intreq), 32'h0);
      step();
      rd("cause_ip0", 5'd13, 32'h0000_0400);
      check("intreq_ip0", 32'(intreq), 32'h1);
      hwint = 6'h02;
      step();
      rd("cause_ip1", 5'd13, 32'h0000_0800);
      check("intreq_masked", 32'(intreq), 32'h0);
      hwint = 6'h01;
      step();
      check("intreq_again", 32'(intreq), 32'h1);

      // Interrupt entry
      exlset = 1'b1; pc_in = 32'h0000_3047;
      step();
      exlset = 1'b0;
      rd("entry_epc", 5'd14, 32'h0000_3044);
      check("entry_epc_out", epc_out, 32'h0000_3044);
      rd("entry_sr", 5'd12, 32'h0000_0403);
      check("entry_intreq", 32'(intreq), 32'h0);

      // Return
      exlclr = 1'b1;
      step();
      exlclr = 1'b0;
      rd("eret_sr", 5'd12, 32'h0000_0401);
      check("eret_intreq", 32'(intreq), 32'h1);

      // Collision: exlset + exlclr + EPC write
      exlset = 1'b1; exlclr = 1'b1; pc_in = 32'h0000_ABCF;
      mtc0(5'd14, 32'h1234_5678);
      exlset = 1'b0; exlclr = 1'b0;
      rd("coll_epc", 5'd14, 32'h0000_ABCC);
      rd("coll_sr", 5'd12, 32'h0000_0403);

      // SR write with exlset: EXL forced 1
      exlset = 1'b1; pc_in = 32'h0000_0100;
      mtc0(5'd12, 32'h0000_FC01);
      exlset = 1'b0;
      rd("sr_exlset", 5'd12, 32'h0000_FC03);
      // SR write with exlclr: EXL forced 0 despite wdata[1]
      exlclr = 1'b1;
      mtc0(5'd12, 32'h0000_0403);
      exlclr = 1'b0;
      rd("sr_exlclr", 5'd12, 32'h0000_0401);

      // EPC software write, alignment, no bypass
      mtc0(5'd14, 32'h0000_2223);
      rd("epc_wr", 5'd14, 32'h0000_2220);
      we = 1'b1; wdata = 32'h0000_5555;
      rd("epc_nobypass", 5'd14, 32'h0000_2220);
      step();
      we = 1'b0;
      rd("epc_wr2", 5'd14, 32'h0000_5554);

      // Ignored writes
      hwint = 6'h00;
      step();
      mtc0(5'd15, 32'hFFFF_FFFF);
      rd("prid", 5'd15, 32'h0000_1902);
      mtc0(5'd13, 32'hFFFF_FFFF);
      rd("cause_ro", 5'd13, 32'h0000_0000);
      mtc0(5'd3, 32'hFFFF_FFFF);
      rd("reg3", 5'd3, 32'h0000_0000);
      mtc0(5'd12, 32'hFFFF_FFFF);
      rd("sr_mask", 5'd12, 32'h0000_FC03);

      // IM5 + IE for the top line
      mtc0(5'd12, 32'h0000_8001);
      check("im5_idle", 32'(intreq), 32'h0);

`ifdef CP0_TIMER_EN
      mtc0(5'd11, 32'd10);
      mtc0(5'd9, 32'd0);
      rd("cnt0", 5'd9, 32'd0);
      rd("cmp", 5'd11, 32'd10);
      for (int i = 1; i <= 10; i++) step();
      rd("cnt10", 5'd9, 32'd10);
      check("tmr_not_yet", 32'(intreq), 32'h0);
      step();
      check("tmr_intreq", 32'(intreq), 32'h1);
      rd("tmr_cause", 5'd13, 32'h0000_8000);
      mtc0(5'd11, 32'd10);
      check("tmr_ack", 32'(intreq), 32'h0);
      mtc0(5'd9, 32'hFFFF_FFFF);
      rd("cnt_max", 5'd9, 32'hFFFF_FFFF);
      step();
      rd("cnt_wrap", 5'd9, 32'h0);
`else
      mtc0(5'd9, 32'h0000_0005);
      rd("cnt_absent", 5'd9, 32'h0);
      mtc0(5'd11, 32'h0000_0005);
      rd("cmp_absent", 5'd11, 32'h0);
`endif

      // hwint[5] path
      hwint = 6'h20;
      step();
      check("hw5_intreq", 32'(intreq), 32'h1);

      // Reset dominates interrupt entry and writes
      reset = 1'b0; exlset = 1'b1; pc_in = 32'h0000_7777;
      we = 1'b1; addr = 5'd12; wdata = 32'h0000_FC01;
      step();
      reset = 1'b1; exlset = 1'b0; we = 1'b0; hwint = 6'h00;
      rd("rst2_sr", 5'd12, 32'h0);
      rd("rst2_epc", 5'd14, 32'h0);
      check("rst2_intreq", 32'(intreq), 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule : tb_cp0_unit
